// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg -- shared constants, the display frame record and the
// hexadecimal seven-segment table for the eight-digit scanner.
package seg_scan_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam int SCAN_DIV_DEFAULT = 100000;
    // Wide enough for the largest legal prescaler terminal count (2^20 - 1).
    localparam int CNT_W            = 20;
    localparam int IDX_W            = 3;

    // One complete display image: eight nibbles, eight dp bits, eight enables.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   mask;
    } disp_frame_t;

    // Hex digit to segments, active-high, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg -- combinational nibble to seven-segment decoder (active-high,
// bit order {a,b,c,d,e,f,g}).
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex7(nib);

endmodule

// File: rtl/seg_scan8.sv
// seg_scan8 -- eight-digit multiplexed seven-segment scanner.
// A prescaler advances the digit index once per SCAN_DIV clocks; new display
// data is staged in a pending register and only swapped into the active
// register at the frame boundary, so a frame never mixes old and new data.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan8
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_mask,
    input  logic        load,
    output logic        ca,
    output logic        cb,
    output logic        cc,
    output logic        cd,
    output logic        ce,
    output logic        cf,
    output logic        cg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        frame
);

    // Scan states are simply the digit index values.
    localparam logic [IDX_W-1:0] S0 = 3'd0;
    localparam logic [IDX_W-1:0] S7 = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_frame_t      pend_q, pend_d;
    disp_frame_t      act_q, act_d;
    disp_frame_t      bus;
    logic             frame_q, frame_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             commit;
    logic [3:0]       nib;
    logic [6:0]       hex_seg;
    logic             digit_on;
    logic             lz_blank;

    // Gather the input bus into one frame record.
    always_comb begin
        bus.value = value;
        bus.dp    = dp_in;
        bus.mask  = en_mask;
    end

    // Prescaler, digit index, pending capture and frame-boundary commit.
    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        commit  = tick && (idx_q == S7);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
        pend_d  = load ? bus : pend_q;
        // A load landing on the commit cycle bypasses pending straight to active.
        act_d   = commit ? (load ? bus : pend_q) : act_q;
        frame_d = commit;
    end

    // Select the current digit's nibble and decode it.
    assign nib = act_q.value[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (hex_seg)
    );

    // Leading-zero detect: a digit is blank when it and every digit above it are zero.
    always_comb begin
`ifdef SEG_SCAN_LZB_EN
        lz_blank = (idx_q != S0) && ((act_q.value >> {idx_q, 2'b00}) == '0);
`else
        lz_blank = 1'b0;
`endif
    end

    // Next anode/segment/dp pattern for the digit currently selected.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        an_d     = 8'hFF;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        digit_on = act_q.mask[idx_q];
        // A blanked zero keeps its anode only when its decimal point must show.
        if (digit_on && (!lz_blank || act_q.dp[idx_q])) begin
            an_d[idx_q] = 1'b0;
        end
        if (digit_on && !lz_blank) begin
            seg_d = ~hex_seg;
        end
        if (digit_on) begin
            dp_d = ~act_q.dp[idx_q];
        end
    end

    // State and output registers with synchronous reset to a dark display.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: pending/active frames are ordinary registers and are cleared
            // on reset so the display stays dark until real data is committed.
            cnt_q   <= '0;
            idx_q   <= S0;
            pend_q  <= '0;
            act_q   <= '0;
            frame_q <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign {ca, cb, cc, cd, ce, cf, cg} = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan8.sv
// tb_seg_scan8 -- self-checking bench for seg_scan8 with SCAN_DIV = 4.
// A time-based reference model (frame position = cycles since reset modulo
// one frame) predicts every output each cycle; directed steps add explicit
// checks at the interesting points.
module tb_seg_scan8;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  en_mask;
    logic        load;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [7:0]  an;
    logic        frame;
    logic [6:0]  seg_obs;

    always #5 clk = ~clk;

    seg_scan8 #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .dp_in   (dp_in),
        .en_mask (en_mask),
        .load    (load),
        .ca      (ca),
        .cb      (cb),
        .cc      (cc),
        .cd      (cd),
        .ce      (ce),
        .cf      (cf),
        .cg      (cg),
        .dp      (dp),
        .an      (an),
        .frame   (frame)
    );

    assign seg_obs = {ca, cb, cc, cd, ce, cf, cg};

    // Digit shapes {a..g}, active-high, written out from the display table.
    logic [6:0] shape [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // ---------------- reference model ----------------
    int          m_k;                 // cycles since reset, modulo one frame
    logic [31:0] m_pv, m_av;          // pending / shown value
    logic [7:0]  m_pd, m_ad;          // pending / shown dp
    logic [7:0]  m_pm, m_am;          // pending / shown enable
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    function automatic logic blanked(input logic [31:0] v, input int slot);
`ifdef SEG_SCAN_LZB_EN
        return (slot != 0) && ((v >> (4 * slot)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_an(input logic [31:0] v, input logic [7:0] d,
                                            input logic [7:0] m, input int slot);
        if (m[slot] && (!blanked(v, slot) || d[slot])) return ~(8'd1 << slot);
        return 8'hFF;
    endfunction

    function automatic logic [6:0] model_seg(input logic [31:0] v, input logic [7:0] m,
                                             input int slot);
        if (m[slot] && !blanked(v, slot)) return ~shape[(v >> (4 * slot)) % 16];
        return 7'h7F;
    endfunction

    function automatic logic model_dp(input logic [7:0] d, input logic [7:0] m, input int slot);
        return m[slot] ? ~d[slot] : 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_k     <= 0;
            m_pv    <= '0; m_pd <= '0; m_pm <= '0;
            m_av    <= '0; m_ad <= '0; m_am <= '0;
            e_an    <= 8'hFF;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            e_frame <= 1'b0;
        end else begin
            e_an    <= model_an(m_av, m_ad, m_am, (m_k / SCAN_DIV) % 8);
            e_seg   <= model_seg(m_av, m_am, (m_k / SCAN_DIV) % 8);
            e_dp    <= model_dp(m_ad, m_am, (m_k / SCAN_DIV) % 8);
            e_frame <= (m_k == FRAME - 1);
            if (load) begin
                m_pv <= value; m_pd <= dp_in; m_pm <= en_mask;
            end
            if (m_k == FRAME - 1) begin
                m_av <= load ? value   : m_pv;
                m_ad <= load ? dp_in   : m_pd;
                m_am <= load ? en_mask : m_pm;
            end
            m_k <= (m_k + 1) % FRAME;
        end
    end

    // ---------------- checking helpers ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("an", {24'd0, an}, {24'd0, e_an});
        check("seg", {25'd0, seg_obs}, {25'd0, e_seg});
        check("dp", {31'd0, dp}, {31'd0, e_dp});
        check("frame", {31'd0, frame}, {31'd0, e_frame});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the frame pulse is seen; a missing pulse is a failure.
    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 2 && !seen; i++) begin
            step();
            if (frame === 1'b1) seen = 1'b1;
        end
        check("frame_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Step until the model reaches a given position within the frame.
    task automatic wait_k(input int target);
        for (int i = 0; i < FRAME + 1 && m_k != target; i++) step();
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] m);
        value   = v;
        dp_in   = d;
        en_mask = m;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   fc;
        int   n2;
        logic flag;
        logic [7:0] lz_an  [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
        logic [6:0] lz_seg [8] = '{7'b0000001, 7'b0001000, 7'h7F, 7'h7F,
                                   7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic       lz_dp  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; en_mask = '0;
        steps(2);
        rst = 1'b0;

        // Reset state: dark display.
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg_obs}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);

        // Idle after reset: stays dark, frame every 32 cycles.
        fc = 0; flag = 1'b0;
        for (int i = 0; i < 96; i++) begin
            step();
            if (frame) fc++;
            if (an !== 8'hFF || seg_obs !== 7'h7F) flag = 1'b1;
        end
        check("idle_frames", fc, 3);
        check("idle_dark", {31'd0, flag}, 32'd0);

        // Basic image: digit 0 shows "7", digit 7 shows "0".
        pulse_load(32'h0123_4567, 8'h00, 8'hFF);
        wait_frame();
        step();
        check("s0_an", {24'd0, an}, 32'hFE);
        check("s0_seg", {25'd0, seg_obs}, {25'd0, 7'b0001111});
        steps(28);
        check("s7_an", {24'd0, an}, 32'h7F);
        check("s7_seg", {25'd0, seg_obs}, {25'd0, 7'b0000001});

        // Two loads in one frame: only the later one ever appears.
        wait_k(2);
        pulse_load(32'h1111_1111, 8'h00, 8'hFF);
        steps(5);
        pulse_load(32'h2222_2222, 8'h00, 8'hFF);
        wait_frame();
        flag = 1'b0; n2 = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (seg_obs === 7'b1001111) flag = 1'b1;
            if (seg_obs === 7'b0010010) n2++;
        end
        check("no_one_shown", {31'd0, flag}, 32'd0);
        check("two_all_slots", n2, FRAME);

        // Load on the commit cycle bypasses pending.
        wait_k(FRAME - 1);
        pulse_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
        check("bypass_frame", {31'd0, frame}, 32'd1);
        step();
        check("bypass_seg", {25'd0, seg_obs}, {25'd0, 7'b0111000});
        fc = 0;
        for (int i = 0; i < FRAME - 2; i++) begin
            step();
            if (frame) fc++;
        end
        check("bypass_frame_once", fc, 0);

        // Partial enable mask and a single decimal point.
        pulse_load($urandom, 8'h02, 8'h0F);
        wait_frame();
        flag = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            step();
            if (an[7:4] !== 4'hF) flag = 1'b1;
            if (j % 4 == 0 && j < 16)
                check($sformatf("dp_slot%0d", j / 4), {31'd0, dp}, (j == 4) ? 32'd0 : 32'd1);
        end
        check("upper_anodes_dark", {31'd0, flag}, 32'd0);

        // Reset mid-frame with load asserted: pending discarded, display dark.
        pulse_load($urandom, 8'($urandom), 8'hFF);
        steps(3);
        rst = 1'b1; load = 1'b1; value = $urandom; en_mask = 8'hFF;
        step();
        rst = 1'b0; load = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (an !== 8'hFF) flag = 1'b1;
        end
        check("rst_discard", {31'd0, flag}, 32'd0);

        // Randomised loads at random points, checked cycle by cycle.
        for (int it = 0; it < 8; it++) begin
            steps($urandom_range(1, 20));
            pulse_load($urandom, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                steps($urandom_range(0, 10));
                pulse_load($urandom, 8'($urandom), 8'($urandom));
            end
            steps($urandom_range(FRAME, 2 * FRAME));
        end

`ifdef SEG_SCAN_LZB_EN
        // Leading-zero blanking with a dp on a blanked digit.
        pulse_load(32'h0000_00A0, 8'h10, 8'hFF);
        wait_frame();
        for (int j = 0; j < FRAME; j++) begin
            step();
            if (j % 4 == 0) begin
                check($sformatf("lzb_an%0d", j / 4), {24'd0, an}, {24'd0, lz_an[j / 4]});
                check($sformatf("lzb_seg%0d", j / 4), {25'd0, seg_obs}, {25'd0, lz_seg[j / 4]});
                check($sformatf("lzb_dp%0d", j / 4), {31'd0, dp}, {31'd0, lz_dp[j / 4]});
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
